// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to route the four multiply ops through a single-cycle multiplier.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);
  // state   | meaning
  // IDLE    | waiting for an accepted start
  // CALC    | one multiply/divide iteration per edge, XLEN edges
  // DONE    | result valid on out, done pulsed for this cycle
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [2:0]      fn_q;
  logic            neg_q;
  logic [XLEN-1:0] opr_q;
  logic [2*XLEN:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic            accept;
  logic            s1_sgn, s2_sgn, neg1, neg2, neg_in;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign busy = (state == ST_CALC);
  assign done = (state == ST_DONE);

  assign accept = (state == ST_IDLE) && start && !flush;

  always_comb begin
    s1_sgn = (fn == FN_MUL) || (fn == FN_MULH) || (fn == FN_MULHSU) ||
             (fn == FN_DIV) || (fn == FN_REM);
    s2_sgn = (fn == FN_MUL) || (fn == FN_MULH) || (fn == FN_DIV) || (fn == FN_REM);
    neg1   = s1_sgn & src1[XLEN-1];
    neg2   = s2_sgn & src2[XLEN-1];
    mag1   = neg1 ? -src1 : src1;
    mag2   = neg2 ? -src2 : src2;
    // a remainder follows the dividend's sign; products and quotients follow the xor
    neg_in = (fn == FN_REM) ? neg1 : (neg1 ^ neg2);
  end

  always_comb begin
    div_zero    = fn[2] && (src2 == '0);
    div_ovf     = ((fn == FN_DIV) || (fn == FN_REM)) && (src1 == INT_MIN) && (src2 == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = fn[1] ? src1 : '1;
    else if (div_ovf)
      special_res = fn[1] ? '0 : INT_MIN;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] ext1, ext2, prod_fast;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    ext1      = {{XLEN{neg1}}, src1};
    ext2      = {{XLEN{neg2}}, src2};
    prod_fast = ext1 * ext2;
    fast_res  = (fn == FN_MUL) ? prod_fast[XLEN-1:0] : prod_fast[2*XLEN-1:XLEN];
  end
`endif

  // acc_q holds {hi partial product, multiplier} or {partial remainder, dividend/quotient}
  logic [XLEN:0]     rem_sh, diff, sum;
  logic [2*XLEN:0]   div_nxt, mul_nxt, acc_nxt;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, result;

  always_comb begin
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = rem_sh - {1'b0, opr_q};
    div_nxt = diff[XLEN] ? {rem_sh, acc_q[XLEN-2:0], 1'b0}
                         : {diff,   acc_q[XLEN-2:0], 1'b1};
    sum     = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opr_q} : '0);
    mul_nxt = {1'b0, sum, acc_q[XLEN-1:1]};
    acc_nxt = fn_q[2] ? div_nxt : mul_nxt;
  end

  always_comb begin
    prod   = acc_nxt[2*XLEN-1:0];
    prod_s = neg_q ? -prod : prod;
    quo    = acc_nxt[XLEN-1:0];
    rem    = acc_nxt[2*XLEN-1:XLEN];
    result = '0;
    case (fn_q)
      FN_MUL:                       result = prod_s[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU: result = prod_s[2*XLEN-1:XLEN];
      FN_DIV, FN_DIVU:              result = neg_q ? -quo : quo;
      FN_REM, FN_REMU:              result = neg_q ? -rem : rem;
      default:                      result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      fn_q  <= '0;
      neg_q <= 1'b0;
      opr_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fn_q  <= fn;
            neg_q <= neg_in;
            cnt_q <= '0;
            if (special) begin
              out   <= special_res;
              state <= ST_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!fn[2]) begin
              out   <= fast_res;
              state <= ST_DONE;
            end
`endif
            else begin
              opr_q <= fn[2] ? mag2 : mag1;
              acc_q <= {{(XLEN+1){1'b0}}, (fn[2] ? mag1 : mag2)};
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              out   <= result;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M vectors, randomized ops against
// a plain-arithmetic reference, flush, mid-operation reset and back-to-back issue.
module tb_muldiv_seq;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  fn = 3'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t dir_tab [14];

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fn(fn), .src1(src1), .src2(src2),
    .flush(flush), .busy(busy), .done(done), .out(out)
  );

  function automatic logic [31:0] ref_op(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Raise start for one edge, then scramble the inputs so late sampling would show.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    fn    = f;
    src1  = a;
    src2  = b;
    @(posedge clk); #1;
    start = 1'b0;
    fn    = 3'($urandom_range(0, 7));
    src1  = $urandom;
    src2  = $urandom;
  endtask

  // Called #1 after the accepting edge; lat counts edges with the accepting edge as 1.
  task automatic wait_done(input bit noise, output logic [31:0] res, output int lat,
                           output int bc, output logic busy_at_done, output logic [1:0] post);
    lat = 1;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        fn    = 3'($urandom_range(0, 7));
        src1  = $urandom;
        src2  = $urandom;
      end
      @(posedge clk); #1;
      lat++;
    end
    res          = out;
    busy_at_done = busy;
    if (noise) begin
      start = 1'b1;
      src1  = $urandom;
      src2  = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
    post  = {done, busy};
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (out !== 32'd0) begin n_err++; $display("FAIL reset_out: got %h want 0", out); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({done, busy} !== 2'b00) begin
      n_err++; $display("FAIL idle_after_reset: done,busy got %b want 00", {done, busy});
    end
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int lat, bc, el;
    logic bad;
    logic [1:0] post;
    dir_tab = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
      '{3'd5, 32'd100,        32'd7,         32'd14},
      '{3'd7, 32'd100,        32'd7,         32'd2},
      '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
      '{3'd7, 32'd5,          32'd0,         32'd5},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
      '{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF},
      '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB}
    };
    foreach (dir_tab[i]) begin
      el = exp_lat(dir_tab[i].f, dir_tab[i].a, dir_tab[i].b);
      issue(dir_tab[i].f, dir_tab[i].a, dir_tab[i].b);
      wait_done(1'b0, res, lat, bc, bad, post);
      n_vec++;
      if (res !== dir_tab[i].e) begin
        n_err++; $display("FAIL dir%0d_out fn=%0d: got %h want %h", i, dir_tab[i].f, res, dir_tab[i].e);
      end
      n_vec++;
      if (lat != el) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, el); end
      n_vec++;
      if (bc != el - 1) begin n_err++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, el - 1); end
      n_vec++;
      if (bad !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, bad); end
      n_vec++;
      if (post !== 2'b00) begin n_err++; $display("FAIL dir%0d_single_pulse: done,busy got %b want 00", i, post); end
    end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [31:0] a, b, res, exp;
    int lat, bc, el;
    logic bad;
    logic [1:0] post;
    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      a   = rand_operand();
      b   = rand_operand();
      exp = ref_op(f, a, b);
      el  = exp_lat(f, a, b);
      issue(f, a, b);
      wait_done(1'b1, res, lat, bc, bad, post);
      n_vec++;
      if (res !== exp) begin
        n_err++; $display("FAIL rnd%0d_out fn=%0d a=%h b=%h: got %h want %h", i, f, a, b, res, exp);
      end
      n_vec++;
      if (lat != el || bc != el - 1) begin
        n_err++; $display("FAIL rnd%0d_timing: lat %0d busy %0d want lat %0d busy %0d", i, lat, bc, el, el - 1);
      end
      n_vec++;
      if (bad !== 1'b0 || post !== 2'b00) begin
        n_err++; $display("FAIL rnd%0d_done_cycle: busy_at_done %b post %b want 0 00", i, bad, post);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, res, e1, e2;
    int lat, bc;
    logic bad;
    logic [1:0] post;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    a2 = $urandom; b2 = $urandom;
    e1 = ref_op(3'd5, a1, b1);
    e2 = ref_op(3'd1, a2, b2);
    issue(3'd5, a1, b1);
    wait_done(1'b0, res, lat, bc, bad, post);
    issue(3'd1, a2, b2);
    n_vec++;
    if (out !== e1) begin n_err++; $display("FAIL b2b_held_out: got %h want %h", out, e1); end
    wait_done(1'b0, res, lat, bc, bad, post);
    n_vec++;
    if (res !== e2) begin n_err++; $display("FAIL b2b_second_out: got %h want %h", res, e2); end
    n_vec++;
    if (lat != exp_lat(3'd1, a2, b2)) begin
      n_err++; $display("FAIL b2b_latency: got %0d want %0d", lat, exp_lat(3'd1, a2, b2));
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, a, b;
    int lat, bc, n_done;
    logic bad;
    logic [1:0] post;
    issue(3'd5, 32'd100, 32'd7);
    wait_done(1'b0, res, lat, bc, bad, post);
    n_vec++;
    if (res !== 32'd14) begin n_err++; $display("FAIL flush_pre_out: got %h want %h", res, 32'd14); end
    issue(3'd4, $urandom, 32'($urandom_range(3, 999)));
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++;
    if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL flush_abort: done,busy got %b want 00", {done, busy}); end
    n_vec++;
    if (out !== 32'd14) begin n_err++; $display("FAIL flush_out_kept: got %h want %h", out, 32'd14); end
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 0) begin n_err++; $display("FAIL flush_no_done: got %0d pulses want 0", n_done); end
    start = 1'b1; flush = 1'b1; fn = 3'd5; src1 = 32'd9; src2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_vec++;
    if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL flush_blocks_start: done,busy got %b want 00", {done, busy}); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    a = $urandom; b = rand_operand();
    issue(3'd6, a, b);
    wait_done(1'b0, res, lat, bc, bad, post);
    n_vec++;
    if (res !== ref_op(3'd6, a, b) || lat != exp_lat(3'd6, a, b)) begin
      n_err++; $display("FAIL flush_restart: got %h lat %0d want %h lat %0d", res, lat, ref_op(3'd6, a, b), exp_lat(3'd6, a, b));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, a, b;
    int lat, bc;
    logic bad;
    logic [1:0] post;
    issue(3'd5, 32'd100, 32'd7);
    wait_done(1'b0, res, lat, bc, bad, post);
    issue(3'd0, $urandom, $urandom);
    repeat (5) @(posedge clk);
    #1;
`ifndef MULDIV_FAST_MUL_EN
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_busy: got %b want 1", busy); end
`endif
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00 || out !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_clear: busy,done %b out %h want 00 0", {busy, done}, out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a = $urandom; b = $urandom;
    issue(3'd2, a, b);
    wait_done(1'b1, res, lat, bc, bad, post);
    n_vec++;
    if (res !== ref_op(3'd2, a, b)) begin
      n_err++; $display("FAIL rst_mid_recover: got %h want %h", res, ref_op(3'd2, a, b));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
